// File: rtl/cpu_cycle_sequencer.sv
// Per-instruction cycle sequencer: walks the 5/7/12-clock budget of each accepted
// instruction or interrupt entry and reports the microcode phase for each clk_en.
module cpu_cycle_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       instr_valid,
   input  logic [1:0] instr_len,
   input  logic [2:0] micro_steps,
   input  logic       halt_req,
   input  logic       irq_req,
   output logic       ready,
   output logic [1:0] phase,
   output logic [2:0] step_index,
   output logic [3:0] cycle_index,
   output logic       instr_done,
   output logic       irq_ack,
   output logic       irq_active,
   output logic       halted
);

   localparam logic [1:0] ST_READY = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [1:0] CYCLE_NONE      = 2'd0;
   localparam logic [1:0] CYCLE_REG_FETCH = 2'd1;
   localparam logic [1:0] CYCLE_REG_WRITE = 2'd2;

   logic [1:0] r_state;
   logic [3:0] r_len;
   logic [2:0] r_steps;
   logic [3:0] r_cyc;
   logic [2:0] r_step;
   logic       r_irq_active;

   logic [3:0] w_n;
   logic [2:0] w_max;
   logic [2:0] w_s;
   logic [2:0] w_k;
   logic       w_exec;
   logic       w_last;
   logic       w_active;
   logic       w_irq_take;

   always_comb begin
      w_n   = 4'd5;
      w_max = 3'd2;
      case (instr_len)
         2'd1: begin w_n = 4'd7;  w_max = 3'd3; end
         2'd2: begin w_n = 4'd12; w_max = 3'd5; end
         default: begin w_n = 4'd5; w_max = 3'd2; end
      endcase
   end

   assign w_s = (micro_steps > w_max) ? w_max : micro_steps;

   // Step k owns cycles 2k+1 (fetch) and 2k+2 (write): k = (c-1)>>1.
   assign w_k      = r_cyc[3:1] - {2'b00, ~r_cyc[0]};
   assign w_exec   = (r_state == ST_EXEC);
   assign w_last   = (r_cyc == (r_len - 4'd1));
   assign w_active = w_exec && (r_cyc != 4'd0) && (w_k < r_steps);

   assign ready      = (r_state == ST_READY) || (w_exec && w_last);
   assign instr_done = w_exec && w_last;
   assign phase      = !w_active ? CYCLE_NONE :
                       (r_cyc[0] ? CYCLE_REG_FETCH : CYCLE_REG_WRITE);
   assign step_index = w_active ? w_k : r_step;
   assign cycle_index = r_cyc;
   assign irq_active  = r_irq_active;
   assign halted      = (r_state == ST_HALT);

   // HALT only wakes on an interrupt; it never takes halt_req or instr_valid.
   assign w_irq_take = irq_req && (ready || (r_state == ST_HALT));
   assign irq_ack    = clk_en && w_irq_take;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_READY;
         r_len        <= 4'd5;
         r_steps      <= 3'd0;
         r_cyc        <= 4'd0;
         r_step       <= 3'd0;
         r_irq_active <= 1'b0;
      end else if (clk_en) begin
         if (w_active)
            r_step <= w_k;
         if (w_irq_take) begin
            r_state      <= ST_EXEC;
            r_len        <= 4'd12;
            r_steps      <= 3'd5;
            r_cyc        <= 4'd0;
            r_step       <= 3'd0;
            r_irq_active <= 1'b1;
         end else if (ready) begin
            r_cyc        <= 4'd0;
            r_irq_active <= 1'b0;
            if (halt_req) begin
               r_state <= ST_HALT;
            end else if (instr_valid) begin
               r_state <= ST_EXEC;
               r_len   <= w_n;
               r_steps <= w_s;
               r_step  <= 3'd0;
            end else begin
               r_state <= ST_READY;
            end
         end else if (w_exec) begin
            r_cyc <= r_cyc + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer; observed outputs packed as
// {ready, phase, step_index, cycle_index, instr_done, irq_ack, irq_active, halted}.
module tb_cpu_cycle_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       clk_en;
   logic       instr_valid;
   logic [1:0] instr_len;
   logic [2:0] micro_steps;
   logic       halt_req;
   logic       irq_req;
   logic       ready;
   logic [1:0] phase;
   logic [2:0] step_index;
   logic [3:0] cycle_index;
   logic       instr_done;
   logic       irq_ack;
   logic       irq_active;
   logic       halted;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [1:0] EP5 [5] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
   localparam logic [2:0] ES5 [5] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
   localparam logic [1:0] EP7 [7] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
   localparam logic [2:0] ES7 [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2};

   cpu_cycle_sequencer dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .instr_valid(instr_valid),
      .instr_len(instr_len), .micro_steps(micro_steps), .halt_req(halt_req),
      .irq_req(irq_req), .ready(ready), .phase(phase), .step_index(step_index),
      .cycle_index(cycle_index), .instr_done(instr_done), .irq_ack(irq_ack),
      .irq_active(irq_active), .halted(halted)
   );

   always #5 clk = ~clk;

   wire [13:0] obs = {ready, phase, step_index, cycle_index, instr_done, irq_ack, irq_active, halted};

   task automatic test_reset();
      reset = 1'b1; clk_en = 1'b1; instr_valid = 1'b0; instr_len = 2'd0;
      micro_steps = 3'd0; halt_req = 1'b0; irq_req = 1'b0;
      #1;
      n_chk++;
      if (obs !== {1'b1, 2'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL reset_state: got %h want %h", obs, {1'b1, 13'd0});
      end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++;
      if (obs !== {1'b1, 13'd0}) begin
         n_fail++; $display("FAIL reset_release: got %h want %h", obs, {1'b1, 13'd0});
      end
      @(negedge clk);
   endtask

   task automatic test_cycle5();
      instr_valid = 1'b1; instr_len = 2'd0; micro_steps = 3'd2;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_chk++;
         if (obs !== {c == 4, EP5[c], ES5[c], 4'(c), c == 4, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL cycle5 c=%0d: got %h want %h", c, obs,
                     {c == 4, EP5[c], ES5[c], 4'(c), c == 4, 1'b0, 1'b0, 1'b0});
         end
         @(negedge clk);
      end
      #1;
      n_chk++;
      if (obs !== {1'b1, 2'd0, 3'd1, 4'd0, 4'b0000}) begin
         n_fail++; $display("FAIL cycle5_idle: got %h want %h", obs, {1'b1, 2'd0, 3'd1, 8'd0});
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      instr_valid = 1'b1; instr_len = 2'd1; micro_steps = 3'd7;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) begin
            instr_valid = 1'b1; instr_len = 2'd2; micro_steps = 3'd1;
         end
         #1;
         n_chk++;
         if (obs !== {c == 6, EP7[c], ES7[c], 4'(c), c == 6, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL cycle7 c=%0d: got %h want %h", c, obs,
                     {c == 6, EP7[c], ES7[c], 4'(c), c == 6, 1'b0, 1'b0, 1'b0});
         end
         @(negedge clk);
      end
      instr_valid = 1'b0; instr_len = 2'd0; micro_steps = 3'd0;
      for (int c = 0; c < 12; c++) begin
         logic [1:0] ep;
         ep = (c == 1) ? 2'd1 : (c == 2) ? 2'd2 : 2'd0;
         #1;
         n_chk++;
         if (obs !== {c == 11, ep, 3'd0, 4'(c), c == 11, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_cycle12 c=%0d: got %h want %h", c, obs,
                     {c == 11, ep, 3'd0, 4'(c), c == 11, 1'b0, 1'b0, 1'b0});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_irq();
      int n_fetch;
      n_fetch = 0;
      irq_req = 1'b1; instr_valid = 1'b1; instr_len = 2'd0; micro_steps = 3'd0;
      #1;
      n_chk++;
      if (obs !== {1'b1, 2'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL irq_accept: got %h want %h", obs,
                            {1'b1, 2'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
      @(negedge clk);
      irq_req = 1'b0; instr_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         logic [1:0] ep;
         logic [2:0] es;
         ep = (c == 0 || c == 11) ? 2'd0 : (c % 2 == 1) ? 2'd1 : 2'd2;
         es = (c == 0) ? 3'd0 : (c == 11) ? 3'd4 : 3'((c - 1) / 2);
         #1;
         if (phase == 2'd1) n_fetch++;
         n_chk++;
         if (obs !== {c == 11, ep, es, 4'(c), c == 11, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL irq_entry c=%0d: got %h want %h", c, obs,
                     {c == 11, ep, es, 4'(c), c == 11, 1'b0, 1'b1, 1'b0});
         end
         @(negedge clk);
      end
      n_chk++;
      if (n_fetch != 5) begin
         n_fail++; $display("FAIL irq_fetch_count: got %0d want 5", n_fetch);
      end
      #1;
      n_chk++;
      if (obs !== {1'b1, 2'd0, 3'd4, 4'd0, 4'b0000}) begin
         n_fail++; $display("FAIL irq_end: got %h want %h", obs, {1'b1, 2'd0, 3'd4, 8'd0});
      end
      @(negedge clk);
   endtask

   task automatic test_halt();
      halt_req = 1'b1;
      #1;
      n_chk++;
      if (ready !== 1'b1 || halted !== 1'b0) begin
         n_fail++; $display("FAIL halt_accept: ready=%b halted=%b want 1/0", ready, halted);
      end
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         instr_valid = 1'b1; halt_req = (i % 2 == 0);
         #1;
         n_chk++;
         if (obs !== {1'b0, 2'd0, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL halt_hold i=%0d: got %h want %h", i, obs,
                               {1'b0, 2'd0, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
         end
         @(negedge clk);
      end
      instr_valid = 1'b0; halt_req = 1'b0; irq_req = 1'b1;
      #1;
      n_chk++;
      if (obs !== {1'b0, 2'd0, 3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL halt_wake: got %h want %h", obs,
                            {1'b0, 2'd0, 3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      end
      @(negedge clk);
      irq_req = 1'b0;
      for (int c = 0; c < 12; c++) begin
         logic [1:0] ep;
         ep = (c == 0 || c == 11) ? 2'd0 : (c % 2 == 1) ? 2'd1 : 2'd2;
         #1;
         n_chk++;
         if ({ready, phase, cycle_index, instr_done, irq_ack, irq_active, halted} !==
             {c == 11, ep, 4'(c), c == 11, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_irq_entry c=%0d: got r%b p%0d c%0d d%b a%b act%b h%b", c,
                     ready, phase, cycle_index, instr_done, irq_ack, irq_active, halted);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      int c;
      c = 0;
      instr_valid = 1'b1; instr_len = 2'd0; micro_steps = 3'd2;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int i = 0; i < 30 && c < 5; i++) begin
         clk_en  = (i % 3 == 2);
         irq_req = (c == 4) && !clk_en;
         #1;
         n_chk++;
         if (obs !== {c == 4, EP5[c], ES5[c], 4'(c), c == 4, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall i=%0d c=%0d: got %h want %h", i, c, obs,
                     {c == 4, EP5[c], ES5[c], 4'(c), c == 4, 1'b0, 1'b0, 1'b0});
         end
         if (clk_en) c++;
         @(negedge clk);
      end
      clk_en = 1'b1; irq_req = 1'b0;
      n_chk++;
      if (c != 5) begin
         n_fail++; $display("FAIL stall_budget: reached c=%0d want 5", c);
      end
      #1;
      n_chk++;
      if (obs !== {1'b1, 2'd0, 3'd1, 4'd0, 4'b0000}) begin
         n_fail++; $display("FAIL stall_end: got %h want %h", obs, {1'b1, 2'd0, 3'd1, 8'd0});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      instr_valid = 1'b1; instr_len = 2'd2; micro_steps = 3'd5;
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if (obs !== {1'b0, 2'd1, 3'd1, 4'd3, 4'b0000}) begin
         n_fail++; $display("FAIL pre_reset_c3: got %h want %h", obs, {1'b0, 2'd1, 3'd1, 4'd3, 4'd0});
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if (obs !== {1'b1, 13'd0}) begin
         n_fail++; $display("FAIL mid_reset: got %h want %h", obs, {1'b1, 13'd0});
      end
      @(negedge clk);
      reset = 1'b0;
      instr_valid = 1'b1; instr_len = 2'd0; micro_steps = 3'd1;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         logic [1:0] ep;
         ep = 2'(c);
         #1;
         n_chk++;
         if (obs !== {1'b0, ep, 3'd0, 4'(c), 4'b0000}) begin
            n_fail++; $display("FAIL post_reset c=%0d: got %h want %h", c, obs,
                               {1'b0, ep, 3'd0, 4'(c), 4'd0});
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_cycle5();
      test_back_to_back();
      test_irq();
      test_halt();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_cycle_sequencer.md
# cpu_cycle_sequencer

Per-instruction cycle sequencer for the E0C6S46-style CPU core. It accepts a decoded instruction, its length class (5, 7 or 12 clocks) and its microcode step count. It then walks the cycle budget and emits, on each CPU clock enable, which microcode phase the register file and ALU perform: none, register fetch or register write. It also owns the HALT state and schedules interrupt entry as a fixed 12-cycle pseudo-instruction. It sits between the instruction decoder and the register/ALU datapath.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  CPU clock enable; all state advances only when high
- instr_valid  in  1  decoder has an instruction ready
- instr_len  in  2  length class: 0=CYCLE5, 1=CYCLE7, 2=CYCLE12, 3=illegal (treated as CYCLE5)
- micro_steps  in  3  number of fetch/write microcode step pairs, 0..7
- halt_req  in  1  HALT instruction decoded; enter halt
- irq_req  in  1  pending, enabled interrupt
- ready  out  1  sequencer accepts a new request this clk_en
- phase  out  2  microcode_cycle: 0=CYCLE_NONE, 1=CYCLE_REG_FETCH, 2=CYCLE_REG_WRITE
- step_index  out  3  current microcode step, 0-based
- cycle_index  out  4  cycle within current instruction, 0..N-1
- instr_done  out  1  last cycle of current instruction/interrupt entry
- irq_ack  out  1  one-cycle pulse on interrupt acceptance
- irq_active  out  1  high for the duration of interrupt entry
- halted  out  1  in HALT state

## Operation
- States: READY, EXEC, HALT.
- N = 5/7/12 per instr_len; illegal maps to 5.
- Latched steps S = min(micro_steps, max_steps(N)), where max_steps is 2 for N=5, 3 for N=7 and 5 for N=12. Values above the maximum clamp; they are not an error.
- ready = (state==READY) or (state==EXEC and cycle_index==N-1).
- Accept on clk_en with ready high. Priority is irq_req > halt_req > instr_valid.
  - irq: go to EXEC with N=12, S=5 and irq_active=1; irq_ack pulses in the accepting cycle.
  - halt: go to HALT.
  - instr: latch N and S, go to EXEC.
  - none: go to READY, or stay there.
- EXEC: cycle_index starts at 0 and increments on each clk_en.
  - Phase at cycle c: c = 2k+1 with k<S gives REG_FETCH and step_index=k; c = 2k+2 with k<S gives REG_WRITE and step_index=k; all other cycles give NONE. Cycle 0 is always NONE (decode).
  - When phase is NONE, step_index is held at its last value (0 after cycle 0 of a fresh instruction).
- instr_done = (state==EXEC and cycle_index==N-1), combinational.
- Back-to-back: the accept in the last cycle loads the new N and S, and cycle_index returns to 0 with no bubble.
- irq_active clears when the interrupt-entry sequence completes, unless that completion accepts another irq.
- HALT: halted=1, phase NONE. On clk_en with irq_req: irq_ack pulses and EXEC runs interrupt entry. halt_req and instr_valid are ignored in HALT.
- instr_len and micro_steps are sampled only on acceptance. Changes during EXEC have no effect.

## Timing
- Reset (async) sets state=READY and all counters to 0. Outputs after reset: ready=1, phase=0, step_index=0, cycle_index=0, instr_done=0, irq_ack=0, irq_active=0, halted=0.
- Reset mid-EXEC or mid-HALT forces READY immediately and drops all pulses.
- All outputs are functions of registered state plus clk_en and the request inputs (irq_ack only). There is no added latency: phase is valid for the entire clk_en cycle it names.
- With clk_en low, state and outputs hold. irq_ack is gated by clk_en and never asserts while clk_en is low.
- cycle_index never exceeds N-1; there is no wrap without acceptance.
- If irq_req arrives mid-EXEC, it is not taken until the instruction's last cycle.

## Test plan
- Reset, then CYCLE5 with micro_steps=2 and clk_en always high -> phase sequence 0,1,2,1,2; step_index 0,0,0,1,1; instr_done only at cycle 4; ready 1 only at cycle 4.
- CYCLE7 with micro_steps=7 -> S clamped to 3; phases 0,1,2,1,2,1,2; instr_done at cycle 6. The next CYCLE12 is accepted at that cycle; the following cycle shows cycle_index=0 with no idle cycle.
- irq_req and instr_valid both high while READY -> irq_ack for one cycle, irq_active=1 for 12 cycles, 5 fetch/write pairs, then irq_active=0.
- halt_req accepted -> halted=1 and instr_valid ignored for 20 cycles. irq_req then gives irq_ack in the same cycle, halted=0 next cycle, and a 12-cycle entry follows.
- clk_en toggling 1-in-3 during CYCLE5 -> each phase value persists across the stalled cycles; the sequence is identical to the always-enabled case.
- reset asserted at cycle 3 of CYCLE12 -> immediately READY, phase=0, cycle_index=0; the first accept after release starts at cycle 0.
